frv_bitwise_wb: RTL

- Response-side sequencer for the bitwise functional unit: consumes its 64-bit result and result-ready strobe, and converts them into single-register GPR writeback beats.
- 32-bit results produce one beat; 64-bit results (wide rotate) produce two beats to an even/odd register pair.
- Sits between the bitwise unit output and the writeback-stage register-file write port.
- Back-pressures the unit while a response is still draining.

---
 rtl/frv_bitwise_wb_pkg.sv | 17 +
 rtl/frv_bitwise_wb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/frv_bitwise_wb_pkg.sv
// frv_bitwise_wb_pkg
//   Shared definitions for the bitwise-unit writeback sequencer:
//   FSM state encoding and the even/odd register-pair address helper.
package frv_bitwise_wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_LO   = 2'd1,
        WB_HI   = 2'd2
    } wb_state_t;

    // Register of an even/odd pair: keep rd[4:1], select the member with odd.
    function automatic logic [4:0] pair_rd(input logic [4:0] rd, input logic odd);
        return {rd[4:1], odd};
    endfunction

endpackage

// File: rtl/frv_bitwise_wb.sv
// frv_bitwise_wb
//   Turns bitwise-unit results into register-file writeback beats.
//   A narrow (32-bit) result becomes one beat to bw_rd. A wide (64-bit)
//   result becomes two beats: the low word goes to the even register of the
//   pair and the high word goes to the odd register. Beats that target x0
//   can be dropped internally.
//
// Ports
//   g_clk, g_reset           clock, asynchronous active-high reset
//   flush                    drop any held response, return to idle
//   bw_ready/bw_result/
//   bw_wide/bw_rd            response from the bitwise unit
//   bw_accept                block can take a response this cycle
//   wb_valid/wb_rd/wb_data   writeback beat toward the register file
//   wb_ready                 register file accepts the beat
//   busy                     a response is held
//
// Handshakes: a response transfers when bw_ready & bw_accept & !flush.
// A beat transfers when wb_valid & wb_ready. While wb_valid=1 and
// wb_ready=0, the beat is held stable. Only flush or reset withdraws it.
module frv_bitwise_wb
    import frv_bitwise_wb_pkg::*;
#(
    parameter bit SKIP_X0      = 1'b1,
    parameter bit XC_CLASS_BIT = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        bw_ready,
    input  logic [63:0] bw_result,
    input  logic        bw_wide,
    input  logic [4:0]  bw_rd,
    output logic        bw_accept,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        busy
);

    wb_state_t   state, state_nxt;

    logic [31:0] hold_lo;
    logic [31:0] hold_hi;
    logic [4:0]  hold_rd;
    logic        hold_wide;

    logic [4:0]  lo_rd;
    logic [4:0]  hi_rd;
    logic        skip_lo;
    logic        skip_hi;
    logic        lo_done;
    logic        hi_done;
    logic        final_done;
    logic        transfer;
    logic        wide_in;

    assign wide_in = XC_CLASS_BIT ? bw_wide : 1'b0;

    // A wide pair always starts on the even register, even if bw_rd was odd.
    assign lo_rd   = hold_wide ? pair_rd(hold_rd, 1'b0) : hold_rd;
    assign hi_rd   = pair_rd(hold_rd, 1'b1);
    assign skip_lo = SKIP_X0 && (lo_rd == 5'd0);
    assign skip_hi = SKIP_X0 && (hi_rd == 5'd0);

    // A skipped beat completes as if the register file had accepted it.
    assign lo_done    = (state == WB_LO) && (wb_ready || skip_lo);
    assign hi_done    = (state == WB_HI) && (wb_ready || skip_hi);
    assign final_done = (lo_done && !hold_wide) || hi_done;

    assign bw_accept = (state == WB_IDLE) || final_done;
    assign transfer  = bw_ready && bw_accept && !flush;

    // State register
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding registers
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            hold_lo   <= 32'd0;
            hold_hi   <= 32'd0;
            hold_rd   <= 5'd0;
            hold_wide <= 1'b0;
        end else if (transfer) begin
            hold_lo   <= bw_result[31:0];
            hold_hi   <= bw_result[63:32];
            hold_rd   <= bw_rd;
            hold_wide <= wide_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = WB_IDLE;
        end else begin
            case (state)
                WB_IDLE: if (transfer) state_nxt = WB_LO;
                WB_LO: begin
                    if (lo_done) begin
                        if (hold_wide)     state_nxt = WB_HI;
                        else if (transfer) state_nxt = WB_LO;
                        else               state_nxt = WB_IDLE;
                    end
                end
                WB_HI: begin
                    if (hi_done) state_nxt = transfer ? WB_LO : WB_IDLE;
                end
                default: state_nxt = WB_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        wb_valid = 1'b0;
        wb_rd    = lo_rd;
        wb_data  = hold_lo;
        busy     = (state != WB_IDLE);
        case (state)
            WB_LO: wb_valid = !skip_lo;
            WB_HI: begin
                wb_valid = !skip_hi;
                wb_rd    = hi_rd;
                wb_data  = hold_hi;
            end
            default: ;
        endcase
    end

endmodule
